// File: rtl/hash_pkg.sv
// Shared types and constants for the hash feeder: FSM state encoding,
// the on-loop threshold and the WAIT timeout length.
package hash_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StGap,
      StWait,
      StDone
   } state_e;

   localparam logic [7:0] HASH_LOOP_THRESH = 8'd12;
   localparam logic [7:0] TIMEOUT_CYCLES   = 8'd255;

endpackage

// File: rtl/hash_keybuf.sv
// Key byte buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module hash_keybuf #(
   parameter int unsigned Depth = 250
) (
   input  logic       CLK,
   input  logic       wr_en,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [Depth];

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = ({24'd0, rd_addr} < Depth) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/hash_feeder.sv
// Streams a buffered key byte-by-byte into a hash core and collects the digest.
// Define HASH_FEEDER_TIMEOUT_EN to abort WAIT with err after TIMEOUT_CYCLES cycles.
module hash_feeder
   import hash_pkg::*;
#(
   parameter int unsigned MAXLEN = 250
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        wr_en,
   input  logic [7:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic        start,
   input  logic [7:0]  key_length,
   input  logic [7:0]  interval,
   output logic        hash_enable,
   output logic        hash_onloop,
   output logic [7:0]  hash_wcount,
   output logic [7:0]  hash_word,
   output logic [7:0]  hash_key_length,
   output logic [7:0]  hash_interval,
   input  logic        hash_valid,
   input  logic [31:0] hash_hashkey,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] result
);

   state_e      state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  gap_q, gap_d;
   logic [7:0]  klen_q, klen_d;
   logic [7:0]  intv_q, intv_d;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;
`ifdef HASH_FEEDER_TIMEOUT_EN
   logic [7:0]  tmo_q, tmo_d;
`endif

   logic       len_ok;
   logic       buf_we;
   logic [7:0] rd_data;
   logic [7:0] remaining;

   assign len_ok    = (key_length != 8'd0) && ({24'd0, key_length} <= MAXLEN);
   assign busy      = (state_q == StSend) || (state_q == StGap) || (state_q == StWait);
   assign buf_we    = wr_en && !busy && ({24'd0, wr_addr} < MAXLEN);
   assign remaining = klen_q - idx_q;

   hash_keybuf #(
      .Depth (MAXLEN)
   ) u_keybuf (
      .CLK     (CLK),
      .wr_en   (buf_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (idx_q),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      gap_d    = gap_q;
      klen_d   = klen_q;
      intv_d   = intv_q;
      result_d = result_q;
      err_d    = 1'b0;
`ifdef HASH_FEEDER_TIMEOUT_EN
      tmo_d    = tmo_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (len_ok) begin
                  klen_d  = key_length;
                  intv_d  = interval;
                  idx_d   = 8'd0;
                  state_d = StSend;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StSend: begin
            if (idx_q == klen_q - 8'd1) begin
               state_d = StWait;
`ifdef HASH_FEEDER_TIMEOUT_EN
               tmo_d   = 8'd0;
`endif
            end else begin
               idx_d = idx_q + 8'd1;
               if (intv_q != 8'd0) begin
                  gap_d   = intv_q;
                  state_d = StGap;
               end else begin
                  state_d = StSend;
               end
            end
         end
         StGap: begin
            // gap_q counts the idle cycles still to spend, including this one
            if (gap_q == 8'd1) begin
               state_d = StSend;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         StWait: begin
            if (hash_valid) begin
               result_d = hash_hashkey;
               state_d  = StDone;
            end
`ifdef HASH_FEEDER_TIMEOUT_EN
            else if (tmo_q == TIMEOUT_CYCLES - 8'd1) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
`endif
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= StIdle;
         idx_q    <= 8'd0;
         gap_q    <= 8'd0;
         klen_q   <= 8'd0;
         intv_q   <= 8'd0;
         result_q <= 32'd0;
         err_q    <= 1'b0;
`ifdef HASH_FEEDER_TIMEOUT_EN
         tmo_q    <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         gap_q    <= gap_d;
         klen_q   <= klen_d;
         intv_q   <= intv_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef HASH_FEEDER_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   always_comb begin
      hash_enable = (state_q == StSend);
      hash_word   = hash_enable ? rd_data : 8'h00;
      hash_wcount = hash_enable ? remaining : klen_q;
      hash_onloop = hash_enable && (remaining > HASH_LOOP_THRESH);
   end

   assign hash_key_length = klen_q;
   assign hash_interval   = intv_q;
   assign done            = (state_q == StDone);
   assign err             = err_q;
   assign result          = result_q;

endmodule

// File: tb/tb_hash_feeder.sv
// Randomised scoreboard bench for hash_feeder: stimulus pushes expected beats
// and done/err events; a negedge monitor pops and compares them.
module tb_hash_feeder;

   localparam int MAXLEN = 250;

   logic        CLK = 1'b0;
   logic        RST;
   logic        wr_en, start, hash_valid;
   logic [7:0]  wr_addr, wr_data, key_length, interval;
   logic [31:0] hash_hashkey;
   logic        hash_enable, hash_onloop, busy, done, err;
   logic [7:0]  hash_wcount, hash_word, hash_key_length, hash_interval;
   logic [31:0] result;

   hash_feeder #(
      .MAXLEN (MAXLEN)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .start           (start),
      .key_length      (key_length),
      .interval        (interval),
      .hash_enable     (hash_enable),
      .hash_onloop     (hash_onloop),
      .hash_wcount     (hash_wcount),
      .hash_word       (hash_word),
      .hash_key_length (hash_key_length),
      .hash_interval   (hash_interval),
      .hash_valid      (hash_valid),
      .hash_hashkey    (hash_hashkey),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .result          (result)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] word;
      logic [7:0] wcount;
      logic       onloop;
      int         cyc;
   } beat_t;

   typedef struct {
      bit          is_done;
      logic [31:0] val;
      int          cyc;
   } ev_t;

   beat_t       beat_q[$];
   ev_t         ev_q[$];
   logic [7:0]  mem_m [256];
   logic [7:0]  exp_klen = 8'd0;
   logic [7:0]  exp_intv = 8'd0;
   logic [31:0] exp_result = 32'd0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
      end
   endfunction

   // Monitor: pops expected beats/events whenever the DUT presents them.
   always @(negedge CLK) begin
      if (RST === 1'b1) begin
         if (hash_enable) begin
            if (beat_q.size() == 0) begin
               chk("unexpected_beat", 32'(hash_wcount), 32'hFFFF_FFFF);
            end else begin
               beat_t b;
               b = beat_q.pop_front();
               chk("beat_word", 32'(hash_word), 32'(b.word));
               chk("beat_wcount", 32'(hash_wcount), 32'(b.wcount));
               chk("beat_onloop", 32'(hash_onloop), 32'(b.onloop));
               chk("beat_cycle", cyc, b.cyc);
            end
         end else begin
            chk("idle_word", 32'(hash_word), 32'd0);
            chk("idle_onloop", 32'(hash_onloop), 32'd0);
            chk("idle_wcount", 32'(hash_wcount), 32'(exp_klen));
         end
         chk("key_length_out", 32'(hash_key_length), 32'(exp_klen));
         chk("interval_out", 32'(hash_interval), 32'(exp_intv));
         if (done) begin
            if (ev_q.size() == 0 || !ev_q[0].is_done) begin
               chk("unexpected_done", 32'(done), 32'd0);
               if (ev_q.size() != 0) void'(ev_q.pop_front());
            end else begin
               ev_t e;
               e = ev_q.pop_front();
               exp_result = e.val;
               chk("done_cycle", cyc, e.cyc);
               chk("done_busy", 32'(busy), 32'd0);
            end
         end
         if (err) begin
            if (ev_q.size() == 0 || ev_q[0].is_done) begin
               chk("unexpected_err", 32'(err), 32'd0);
               if (ev_q.size() != 0) void'(ev_q.pop_front());
            end else begin
               ev_t e;
               e = ev_q.pop_front();
               chk("err_cycle", cyc, e.cyc);
            end
         end
         chk("result", result, exp_result);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input int addr, input logic [7:0] data, input bit model_busy);
      wr_en   = 1'b1;
      wr_addr = 8'(addr);
      wr_data = data;
      tick();
      wr_en = 1'b0;
      if (!model_busy && addr < MAXLEN) mem_m[addr] = data;
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_enable"}, 32'(hash_enable), 32'd0);
      chk({tag, "_onloop"}, 32'(hash_onloop), 32'd0);
      chk({tag, "_word"}, 32'(hash_word), 32'd0);
      chk({tag, "_wcount"}, 32'(hash_wcount), 32'd0);
      chk({tag, "_klen"}, 32'(hash_key_length), 32'd0);
      chk({tag, "_intv"}, 32'(hash_interval), 32'd0);
      chk({tag, "_result"}, result, 32'd0);
   endtask

   task automatic do_reset();
      RST = 1'b0;
      #1;
      check_all_zero("reset");
      beat_q.delete();
      ev_q.delete();
      exp_klen   = 8'd0;
      exp_intv   = 8'd0;
      exp_result = 32'd0;
      tick();
      tick();
      RST = 1'b1;
   endtask

   task automatic bad_start(input int k);
      ev_t e;
      start      = 1'b1;
      key_length = 8'(k);
      interval   = 8'd1;
      e.is_done  = 1'b0;
      e.val      = 32'd0;
      e.cyc      = cyc + 1;
      ev_q.push_back(e);
      tick();
      start = 1'b0;
      chk("bad_start_busy", 32'(busy), 32'd0);
      tick();
      tick();
      chk("bad_start_busy_later", 32'(busy), 32'd0);
   endtask

   // mode 0: normal, 1: junk start/write/valid mid-stream, 2: reset at beat 7,
   // 3: never answer in WAIT
   task automatic run(input int k, input int intv, input int mode, input logic [31:0] key);
      int n, last, wait_entry, m;
      n          = cyc;
      start      = 1'b1;
      key_length = 8'(k);
      interval   = 8'(intv);
      tick();
      start    = 1'b0;
      exp_klen = 8'(k);
      exp_intv = 8'(intv);
      for (int i = 0; i < k; i++) begin
         beat_t b;
         b.word   = mem_m[i];
         b.wcount = 8'(k - i);
         b.onloop = (k - i) > 12;
         b.cyc    = n + 1 + i * (intv + 1);
         beat_q.push_back(b);
      end
      last       = n + 1 + (k - 1) * (intv + 1);
      wait_entry = last + 1;
      chk("busy_after_start", 32'(busy), 32'd1);

      if (mode == 2) begin
         while (cyc < n + 1 + 7 * (intv + 1)) tick();
         chk("pre_reset_enable", 32'(hash_enable), 32'd1);
         do_reset();
         for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_busy", 32'(busy), 32'd0);
         end
         return;
      end

      while (cyc < wait_entry) begin
         if (mode == 1 && cyc == n + 3) begin
            start        = 1'b1;
            key_length   = 8'd5;
            interval     = 8'd0;
            hash_valid   = 1'b1;
            hash_hashkey = 32'h1234_5678;
            wr(k - 1, ~mem_m[k - 1], 1'b1);
            start      = 1'b0;
            hash_valid = 1'b0;
         end else begin
            tick();
         end
      end
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_enable", 32'(hash_enable), 32'd0);

      if (mode == 3) begin
`ifdef HASH_FEEDER_TIMEOUT_EN
         begin
            ev_t e;
            e.is_done = 1'b0;
            e.val     = 32'd0;
            e.cyc     = wait_entry + 255;
            ev_q.push_back(e);
         end
         while (cyc < wait_entry + 257) tick();
         chk("timeout_busy", 32'(busy), 32'd0);
`else
         for (int i = 0; i < 300; i++) tick();
         chk("no_timeout_busy", 32'(busy), 32'd1);
         do_reset();
`endif
         return;
      end

      for (int d = $urandom_range(0, 4); d > 0; d--) tick();
      m = cyc;
      hash_valid   = 1'b1;
      hash_hashkey = key;
      begin
         ev_t e;
         e.is_done = 1'b1;
         e.val     = key;
         e.cyc     = m + 1;
         ev_q.push_back(e);
      end
      tick();
      hash_valid = 1'b0;
      tick();
      chk("after_done_busy", 32'(busy), 32'd0);
      chk("beats_left", beat_q.size(), 0);
      chk("events_left", ev_q.size(), 0);
   endtask

   initial begin
      RST          = 1'b0;
      wr_en        = 1'b0;
      wr_addr      = 8'd0;
      wr_data      = 8'd0;
      start        = 1'b0;
      key_length   = 8'd0;
      interval     = 8'd0;
      hash_valid   = 1'b0;
      hash_hashkey = 32'd0;
      tick();
      tick();
      check_all_zero("por");
      RST = 1'b1;
      tick();

      for (int i = 0; i < 15; i++) wr(i, 8'(i + 1), 1'b0);
      run(15, 0, 0, 32'hDEAD_BEEF);
      run(15, 2, 0, $urandom);
      bad_start(0);
      bad_start(MAXLEN + 1);
      run(15, 1, 1, $urandom);
      wr(MAXLEN, 8'hAA, 1'b0);

      for (int t = 0; t < 6; t++) begin
         int k, iv;
         k  = (t == 0) ? 1 : (t == 1) ? MAXLEN : $urandom_range(2, 40);
         iv = (t == 0) ? 5 : (t == 1) ? 0 : $urandom_range(0, 3);
         for (int i = 0; i < k; i++) wr(i, 8'($urandom), 1'b0);
         run(k, iv, 0, $urandom);
      end

      for (int i = 0; i < 15; i++) wr(i, 8'($urandom), 1'b0);
      run(15, 1, 2, 32'd0);
      run(15, 1, 0, $urandom);
      run(13, 0, 3, 32'd0);

      tick();
      tick();
      chk("final_beats_left", beat_q.size(), 0);
      chk("final_events_left", ev_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hash_feeder.md
HASH_FEEDER -- requirements
Module: hash_feeder

Interface
REQ-001 SHALL have parameter MAXLEN, default 250, meaning key buffer depth in bytes (maximum key_length).
REQ-002 SHALL have ports: CLK  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port RST  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports wr_en in 1, wr_addr in 8, wr_data in 8: key buffer byte write.
REQ-005 SHALL have ports start in 1, key_length in 8, interval in 8: launch a hash of buffer bytes 0..key_length-1.
REQ-006 SHALL have outputs to the hash core: hash_enable 1, hash_onloop 1, hash_wcount 8, hash_word 8, hash_key_length 8, hash_interval 8.
REQ-007 SHALL have inputs from the hash core: hash_valid 1, hash_hashkey 32.
REQ-008 SHALL have status outputs busy 1, done 1 (one-cycle pulse), err 1 (one-cycle pulse), result 32.

Function
REQ-009 SHALL write wr_data to buffer[wr_addr] when wr_en=1, busy=0 and wr_addr<MAXLEN; otherwise drop the write.
REQ-010 SHALL use FSM states IDLE, SEND, GAP, WAIT, DONE.
REQ-011 IDLE: start=1 with 1<=key_length<=MAXLEN latches key_length/interval, sets idx=0, enters SEND next cycle; busy=1 from that cycle.
REQ-012 IDLE: start=1 with key_length=0 or >MAXLEN SHALL pulse err next cycle and remain IDLE.
REQ-013 SEND: one cycle; hash_enable=1, hash_word=buffer[idx], hash_wcount=key_length-idx, hash_onloop=1 iff hash_wcount>12.
REQ-014 After SEND: last byte (idx=key_length-1) goes to WAIT; else idx+1 and to GAP if interval>0, else SEND.
REQ-015 GAP: hash_enable=0 for exactly interval cycles, then SEND.
REQ-016 Outside SEND: hash_enable=0, hash_onloop=0, hash_word=0, hash_wcount=latched key_length.
REQ-017 hash_key_length and hash_interval SHALL present latched values throughout busy.
REQ-018 WAIT: on hash_valid=1 latch hash_hashkey into result, enter DONE.
REQ-019 DONE: pulse done=1 one cycle, return to IDLE; busy=0 in DONE.
REQ-020 start while busy SHALL be ignored; hash_valid outside WAIT ignored.
REQ-021 Stream length SHALL be key_length + (key_length-1)*interval cycles from first SEND to last SEND inclusive.

Reset
REQ-022 RST=0 SHALL asynchronously force IDLE, idx=0, busy/done/err/hash_enable/hash_onloop=0, hash_word/hash_wcount/hash_key_length/hash_interval=0, result=0.
REQ-023 Buffer contents SHALL not be reset; reset mid-stream aborts without done or err.

Configuration
REQ-024 Macro HASH_FEEDER_TIMEOUT_EN defined: WAIT holds an 8-bit counter; 255 cycles without hash_valid pulses err, leaves result unchanged, returns to IDLE.
REQ-025 Macro undefined: WAIT has no timeout and waits indefinitely; no counter logic.

Structure
REQ-026 FSM state enum, HASH_LOOP_THRESH=12 and TIMEOUT_CYCLES=255 SHALL live in shared package hash_pkg.
REQ-027 Key buffer SHALL be sub-module hash_keybuf (one write port, one async read port, MAXLEN x 8).

Verification
REQ-028 Load bytes 0x01..0x0F, start key_length=15 interval=0 -> 15 consecutive enable cycles, wcount 15..1, onloop high on first 3 beats, words 0x01..0x0F.
REQ-029 Same key, interval=2 -> 2 idle cycles between beats, 43 cycles first to last beat, onloop high only for wcount 15,14,13.
REQ-030 In WAIT drive hash_valid with 0xDEADBEEF -> result=0xDEADBEEF, done pulse next cycle, busy=0.
REQ-031 start key_length=0, then key_length=251 -> err pulse each, no enable cycles, busy stays 0.
REQ-032 Second start and wr_en mid-stream -> ignored, buffer unchanged; RST=0 at beat 7 -> all outputs 0 immediately, no done.
REQ-033 TIMEOUT_EN defined, no hash_valid -> err pulse 255 cycles after WAIT entry; undefined -> busy stays 1.
